mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: word type, RAM status codes,
// arbiter FSM states and the fairness grant marker.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IGRANT = 2'd1,
      DGRANT = 2'd2
   } arb_state_t;

   // Which requester owned the most recently completed transfer
   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of icache, dcache and RAM-side signals seen by the arbiter.
// master: the arbiter itself; slave: the caches and RAM around it.
interface mem_arbiter_if #(parameter int WORD_W = 32);
   import cpu_types_pkg::*;

   logic              iREN;
   logic [WORD_W-1:0] iaddr;
   logic              iwait;
   logic [WORD_W-1:0] iload;

   logic              dREN;
   logic              dWEN;
   logic [WORD_W-1:0] daddr;
   logic [WORD_W-1:0] dstore;
   logic              dwait;
   logic [WORD_W-1:0] dload;

   logic              ramREN;
   logic              ramWEN;
   logic [WORD_W-1:0] ramaddr;
   logic [WORD_W-1:0] ramstore;
   logic [WORD_W-1:0] ramload;
   ramstate_t         ramstate;

   modport master (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

   modport slave (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter (icache / dcache). Grants one requester at a
// time, completes on ACCESS, retries on ERROR, aborts on request withdrawal.
// Ties alternate: data wins unless the last completed grant was data.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic          CLK,
   input  logic          RST,
   mem_arbiter_if.master bus
);

   arb_state_t state_q, state_d;
   grant_t     last_grant_q, last_grant_d;
   logic       d_req_s;

   assign d_req_s = bus.dREN | bus.dWEN;

   // Read data is passed straight through; callers only trust it on wait-low
   assign bus.iload = bus.ramload;
   assign bus.dload = bus.ramload;

   // State and fairness registers; reset abandons any grant immediately
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_I;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Next-state and fairness update
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (d_req_s && !(bus.iREN && (last_grant_q == GRANT_D))) begin
               state_d = DGRANT;
            end else if (bus.iREN) begin
               state_d = IGRANT;
            end else begin
               state_d = IDLE;
            end
         end
         IGRANT: begin
            if (!bus.iREN) begin
               state_d = IDLE;                 // aborted, fairness untouched
            end else if (bus.ramstate == ACCESS) begin
               state_d      = IDLE;
               last_grant_d = GRANT_I;
            end else if (bus.ramstate == ERROR) begin
               state_d = IDLE;                 // retry through rearbitration
            end else begin
               state_d = IGRANT;
            end
         end
         DGRANT: begin
            if (!d_req_s) begin
               state_d = IDLE;
            end else if (bus.ramstate == ACCESS) begin
               state_d      = IDLE;
               last_grant_d = GRANT_D;
            end else if (bus.ramstate == ERROR) begin
               state_d = IDLE;
            end else begin
               state_d = DGRANT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // RAM drive and wait handshakes for the current grant
   always_comb begin
      bus.iwait    = 1'b1;
      bus.dwait    = 1'b1;
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = {WORD_W{1'b0}};
      bus.ramstore = {WORD_W{1'b0}};
      case (state_q)
         IGRANT: begin
            if (bus.iREN) begin
               bus.ramREN  = 1'b1;
               bus.ramaddr = bus.iaddr;
               if (bus.ramstate == ACCESS) begin
                  bus.iwait = 1'b0;
               end else begin
                  bus.iwait = 1'b1;
               end
            end else begin
               bus.ramREN = 1'b0;
            end
         end
         DGRANT: begin
            if (bus.dWEN) begin
               // a simultaneous read+write request is served as a write
               bus.ramWEN   = 1'b1;
               bus.ramaddr  = bus.daddr;
               bus.ramstore = bus.dstore;
            end else if (bus.dREN) begin
               bus.ramREN  = 1'b1;
               bus.ramaddr = bus.daddr;
            end else begin
               bus.ramREN = 1'b0;
            end
            if (d_req_s && (bus.ramstate == ACCESS)) begin
               bus.dwait = 1'b0;
            end else begin
               bus.dwait = 1'b1;
            end
         end
         default: begin
            bus.iwait = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Stimulus pushes the expected wait pulse
// into a scoreboard queue; a negedge monitor pops and checks each pulse.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   typedef struct {
      logic  is_d;
      logic  chk_data;
      word_t data;
   } exp_t;

   logic CLK;
   logic RST;
   int   total;
   int   bad;
   exp_t exp_q[$];

   logic  snap_ren, snap_wen, snap_iwait, snap_dwait;
   word_t snap_addr, snap_store;
   int    ren_cnt, wen_cnt;

   mem_arbiter_if #(.WORD_W(32)) bus ();

   mem_arbiter #(.WORD_W(32)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic is_d, input logic chk_data, input word_t data);
      exp_t e;
      e.is_d     = is_d;
      e.chk_data = chk_data;
      e.data     = data;
      return e;
   endfunction

   // Scoreboard monitor: protocol invariants plus every wait pulse
   always @(negedge CLK) begin
      exp_t e;
      chk("one_wait_low", {31'd0, (!bus.iwait && !bus.dwait)}, 32'd0);
      chk("ren_wen_excl", {31'd0, (bus.ramREN && bus.ramWEN)}, 32'd0);
      if (!bus.iwait || !bus.dwait) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_wait", {30'd0, bus.iwait, bus.dwait}, 32'd3);
         end else begin
            e = exp_q.pop_front();
            chk("wait_port_is_d", {31'd0, !bus.dwait}, {31'd0, e.is_d});
            if (e.chk_data) begin
               chk("load_data", e.is_d ? bus.dload : bus.iload, e.data);
            end
         end
      end
   end

   // One clock cycle with the given RAM status; outputs snapshotted at negedge
   task automatic step(input ramstate_t rs);
      bus.ramstate = rs;
      @(negedge CLK);
      snap_ren   = bus.ramREN;
      snap_wen   = bus.ramWEN;
      snap_iwait = bus.iwait;
      snap_dwait = bus.dwait;
      snap_addr  = bus.ramaddr;
      snap_store = bus.ramstore;
      ren_cnt   += int'(bus.ramREN);
      wen_cnt   += int'(bus.ramWEN);
      @(posedge CLK);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_iwait"},    {31'd0, bus.iwait},  32'd1);
      chk({tag, "_dwait"},    {31'd0, bus.dwait},  32'd1);
      chk({tag, "_ramREN"},   {31'd0, bus.ramREN}, 32'd0);
      chk({tag, "_ramWEN"},   {31'd0, bus.ramWEN}, 32'd0);
      chk({tag, "_ramaddr"},  bus.ramaddr,         32'd0);
      chk({tag, "_ramstore"}, bus.ramstore,        32'd0);
   endtask

   task automatic do_reset();
      RST          = 1'b1;
      bus.iREN     = 1'b0;
      bus.dREN     = 1'b0;
      bus.dWEN     = 1'b0;
      bus.iaddr    = 32'd0;
      bus.daddr    = 32'd0;
      bus.dstore   = 32'd0;
      bus.ramload  = 32'd0;
      bus.ramstate = FREE;
      @(negedge CLK);
      check_idle_outputs("reset");
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      total = 0;
      bad   = 0;
      do_reset();

      // Instruction read: three BUSY cycles then ACCESS
      bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramload = 32'hDEADBEEF;
      exp_q.push_back(mk(1'b0, 1'b1, 32'hDEADBEEF));
      ren_cnt = 0; wen_cnt = 0;
      step(BUSY);
      chk("ird_idle_ren", {31'd0, snap_ren}, 32'd0);
      step(BUSY);
      chk("ird_addr", snap_addr, 32'h40);
      step(BUSY);
      step(BUSY);
      step(ACCESS);
      chk("ird_iwait_low", {31'd0, snap_iwait}, 32'd0);
      bus.iREN = 1'b0;
      step(FREE);
      chk("ird_ren_cycles", ren_cnt, 32'd4);
      chk("ird_queue_empty", exp_q.size(), 32'd0);

      // Fairness from reset: D, then I, then D again
      do_reset();
      bus.iREN = 1'b1; bus.dREN = 1'b1; bus.iaddr = 32'h100; bus.daddr = 32'h200;
      bus.ramload = 32'h11111111;
      exp_q.push_back(mk(1'b1, 1'b1, 32'h11111111));
      step(FREE);
      chk("fair_idle_ren", {31'd0, snap_ren}, 32'd0);
      step(ACCESS);
      chk("fair_first_d_addr", snap_addr, 32'h200);
      chk("fair_first_d_ren", {31'd0, snap_ren}, 32'd1);
      bus.ramload = 32'h22222222;
      exp_q.push_back(mk(1'b0, 1'b1, 32'h22222222));
      step(FREE);
      chk("fair_bubble_ren", {31'd0, snap_ren}, 32'd0);
      step(ACCESS);
      chk("fair_then_i_addr", snap_addr, 32'h100);
      bus.ramload = 32'h33333333;
      exp_q.push_back(mk(1'b1, 1'b1, 32'h33333333));
      step(FREE);
      step(ACCESS);
      chk("fair_then_d_addr", snap_addr, 32'h200);
      bus.iREN = 1'b0; bus.dREN = 1'b0;
      step(FREE);
      chk("fair_queue_empty", exp_q.size(), 32'd0);

      // Data write held until ACCESS; no read enable at any point
      bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h12345678;
      bus.ramload = 32'hA5A5A5A5;
      exp_q.push_back(mk(1'b1, 1'b0, 32'h0));
      ren_cnt = 0; wen_cnt = 0;
      step(FREE);
      step(BUSY);
      chk("wr_addr", snap_addr, 32'h80);
      chk("wr_store", snap_store, 32'h12345678);
      step(BUSY);
      step(ACCESS);
      chk("wr_dwait_low", {31'd0, snap_dwait}, 32'd0);
      bus.dWEN = 1'b0;
      step(FREE);
      chk("wr_wen_cycles", wen_cnt, 32'd3);
      chk("wr_ren_cycles", ren_cnt, 32'd0);

      // Simultaneous dREN and dWEN is a write
      bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h84; bus.dstore = 32'hCAFEF00D;
      exp_q.push_back(mk(1'b1, 1'b0, 32'h0));
      step(FREE);
      step(ACCESS);
      chk("rw_wen", {31'd0, snap_wen}, 32'd1);
      chk("rw_ren", {31'd0, snap_ren}, 32'd0);
      chk("rw_store", snap_store, 32'hCAFEF00D);
      bus.dREN = 1'b0; bus.dWEN = 1'b0;
      step(FREE);
      chk("rw_queue_empty", exp_q.size(), 32'd0);

      // ERROR during an instruction grant: drop, then reissue the same address
      bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.ramload = 32'h0BADF00D;
      step(FREE);
      step(BUSY);
      chk("err_first_addr", snap_addr, 32'h44);
      step(ERROR);
      chk("err_iwait_high", {31'd0, snap_iwait}, 32'd1);
      step(FREE);
      chk("err_gap_ren", {31'd0, snap_ren}, 32'd0);
      step(BUSY);
      chk("err_reissue_ren", {31'd0, snap_ren}, 32'd1);
      chk("err_reissue_addr", snap_addr, 32'h44);
      exp_q.push_back(mk(1'b0, 1'b1, 32'h0BADF00D));
      step(ACCESS);
      bus.iREN = 1'b0;
      step(FREE);
      chk("err_queue_empty", exp_q.size(), 32'd0);

      // Instruction request withdrawn after two BUSY cycles; pending data read follows
      bus.iREN = 1'b1; bus.iaddr = 32'h48;
      step(FREE);
      step(BUSY);
      bus.dREN = 1'b1; bus.daddr = 32'h300;
      step(BUSY);
      bus.iREN = 1'b0;
      step(BUSY);
      chk("abort_ren", {31'd0, snap_ren}, 32'd0);
      chk("abort_iwait", {31'd0, snap_iwait}, 32'd1);
      step(FREE);
      chk("abort_idle_ren", {31'd0, snap_ren}, 32'd0);
      bus.ramload = 32'h5A5A0001;
      exp_q.push_back(mk(1'b1, 1'b1, 32'h5A5A0001));
      step(ACCESS);
      chk("abort_then_d_addr", snap_addr, 32'h300);
      bus.dREN = 1'b0;
      step(FREE);
      chk("abort_queue_empty", exp_q.size(), 32'd0);

      // Asynchronous reset in the middle of a data grant
      bus.dREN = 1'b1; bus.daddr = 32'h500;
      step(FREE);
      step(BUSY);
      chk("rst_mid_addr", snap_addr, 32'h500);
      #2;
      RST = 1'b1;
      #1;
      check_idle_outputs("rst_async");
      step(ACCESS);
      bus.dREN = 1'b0;
      RST = 1'b0;
      step(ACCESS);
      step(FREE);
      chk("rst_queue_empty", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
